// File: rtl/adc_serial_ctrl.sv
// Serial ADC controller: sends a 4-bit channel address, clocks back an NBITS result, waits on eoc.
// Define ADC_AVG_EN to publish the mean of every four frames instead of each frame.
module adc_serial_ctrl #(
    parameter int CLK_DIV = 51,
    parameter int NBITS   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       chan,
    output logic             cs,
    output logic             ADC_clk,
    output logic             data_out_adc,
    input  logic             data_in_adc,
    input  logic             eoc,
    output logic             busy,
    output logic [NBITS-1:0] sample,
    output logic             sample_valid
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (NBITS > 2) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT_EOC_LO,
        WAIT_EOC_HI,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               phase_q, phase_d;   // 0: ADC_clk low half, 1: high half
    logic [NBITS-1:0]   tx_q, tx_d;         // latched channel address, MSB first
    logic [NBITS-1:0]   rx_q, rx_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic               dout_q, dout_d;
    logic [NBITS-1:0]   sample_q, sample_d;
    logic               valid_q, valid_d;

`ifdef ADC_AVG_EN
    logic [NBITS+1:0]   acc_q, acc_d;
    logic [1:0]         avg_cnt_q, avg_cnt_d;
    logic [NBITS+1:0]   acc_sum;

    assign acc_sum = acc_q + {2'b00, rx_q};
`endif

    logic div_last;
    logic bit_last;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_last = (bit_q == BIT_W'(NBITS - 1));

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        dout_d   = dout_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
`ifdef ADC_AVG_EN
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = {chan, {(NBITS-4){1'b0}}};
                    rx_d    = '0;
                    cs_d    = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    dout_d  = tx_q[NBITS-1];
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!phase_q) begin
                        // Capture on the same edge that raises ADC_clk.
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[NBITS-2:0], data_in_adc};
                    end else begin
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (bit_last) begin
                            cs_d    = 1'b1;
                            dout_d  = 1'b0;
                            state_d = WAIT_EOC_LO;
                        end else begin
                            bit_d  = bit_q + BIT_W'(1);
                            tx_d   = tx_q << 1;
                            dout_d = tx_q[NBITS-2];
                        end
                    end
                end
            end

            WAIT_EOC_LO: begin
                if (!eoc) begin
                    state_d = WAIT_EOC_HI;
                end
            end

            WAIT_EOC_HI: begin
                if (eoc) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
`ifdef ADC_AVG_EN
                avg_cnt_d = avg_cnt_q + 2'd1;
                if (avg_cnt_q == 2'd3) begin
                    sample_d = acc_sum[NBITS+1:2];
                    valid_d  = 1'b1;
                    acc_d    = '0;
                end else begin
                    acc_d = acc_sum;
                end
`else
                sample_d = rx_q;
                valid_d  = 1'b1;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            dout_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            dout_q   <= dout_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

`ifdef ADC_AVG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            avg_cnt_q <= 2'd0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
        end
    end
`endif

    assign cs           = cs_q;
    assign ADC_clk      = sclk_q;
    assign data_out_adc = dout_q;
    assign busy         = (state_q != IDLE);
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Self-checking bench for adc_serial_ctrl: acts as the ADC and scoreboards every published sample.
// Works in both builds (ADC_AVG_EN defined or not).
`timescale 1ns/1ps
module tb_adc_serial_ctrl;

    localparam int CLK_DIV = 51;
    localparam int NBITS   = 10;
    localparam int BIT_NS  = 2 * CLK_DIV * 20;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       chan = 4'h0;
    logic             data_in_adc = 1'b0;
    logic             eoc = 1'b1;
    logic             cs;
    logic             ADC_clk;
    logic             data_out_adc;
    logic             busy;
    logic [NBITS-1:0] sample;
    logic             sample_valid;

    adc_serial_ctrl #(.CLK_DIV(CLK_DIV), .NBITS(NBITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .chan         (chan),
        .cs           (cs),
        .ADC_clk      (ADC_clk),
        .data_out_adc (data_out_adc),
        .data_in_adc  (data_in_adc),
        .eoc          (eoc),
        .busy         (busy),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always #10 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;
    int exp_valid = 0;
    int done_cnt  = 0;
    logic [NBITS-1:0] exp_q[$];
    logic [NBITS-1:0] exp_sample = '0;
    logic [NBITS+1:0] acc_model = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst && sample_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("valid_without_frame", {31'b0, sample_valid}, 32'd0);
            end else begin
                exp_sample = exp_q.pop_front();
                check("sample", sample, exp_sample);
            end
        end
    end

    task automatic push_expected(input logic [NBITS-1:0] bits);
        done_cnt++;
`ifdef ADC_AVG_EN
        acc_model = acc_model + {2'b00, bits};
        if (done_cnt % 4 == 0) begin
            exp_q.push_back(acc_model[NBITS+1:2]);
            exp_valid++;
            acc_model = '0;
        end
`else
        exp_q.push_back(bits);
        exp_valid++;
`endif
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_sample = '0;
        acc_model  = '0;
        done_cnt   = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        check("pending_at_reset", exp_q.size(), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        eoc = 1'b1;
        data_in_adc = 1'b0;
        repeat (3) @(negedge clk);
        clear_model();
    endtask

    // Called on a negedge; start is seen at the next rising edge.
    task automatic start_frame(input logic [3:0] ch);
        start = 1'b1;
        chan  = ch;
        @(negedge clk);
        check("start_accept", {31'b0, busy}, 32'd1);
        start = 1'b0;
        chan  = ~ch;
    endtask

    // ADC model for one frame; optionally aborts with reset, pokes start mid-frame, or withholds eoc.
    task automatic serve_frame(input logic [3:0] ch, input logic [NBITS-1:0] bits,
                               input bit abort, input bit poke, input bit do_eoc);
        int nrise = 0;
        int cyc   = 0;
        bit done  = 0;
        logic prev = ADC_clk;
        time last_rise = 0;
        logic [NBITS-1:0] dcap = '0;
        logic [NBITS-1:0] exp_dout = '0;
        int v0;

        exp_dout[NBITS-1 -: 4] = ch;
        data_in_adc = bits[NBITS-1];
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ADC_clk && !prev) begin
                dcap = {dcap[NBITS-2:0], data_out_adc};
                if (nrise > 0) check("rise_gap_ns", 32'($time - last_rise), BIT_NS);
                last_rise = $time;
                nrise++;
                if (nrise == 5) begin
                    check("sample_hold_mid", sample, exp_sample);
                    if (abort) begin
                        v0 = valid_cnt;
                        rst = 1'b0;
                        #1;
                        check("abort_cs", {31'b0, cs}, 32'd1);
                        check("abort_busy", {31'b0, busy}, 32'd0);
                        check("abort_adc_clk", {31'b0, ADC_clk}, 32'd0);
                        check("abort_sample", sample, 32'd0);
                        clear_model();
                        @(negedge clk);
                        rst = 1'b1;
                        repeat (200) @(negedge clk);
                        check("abort_no_valid", valid_cnt, v0);
                        check("abort_idle", {31'b0, busy}, 32'd0);
                        return;
                    end
                end
                if (poke && nrise == 3) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            if (!ADC_clk && prev && nrise < NBITS) data_in_adc = bits[NBITS-1-nrise];
            if (cs && nrise > 0) done = 1;
            prev = ADC_clk;
        end
        check("cs_high_after_frame", {31'b0, cs}, 32'd1);
        check("adc_clk_rises", nrise, NBITS);
        check("data_out_bits", dcap, exp_dout);

        repeat (5) @(negedge clk);
        check("busy_wait_eoc", {31'b0, busy}, 32'd1);
        if (!do_eoc) begin
            v0 = valid_cnt;
            repeat (2000) @(negedge clk);
            check("busy_stuck_no_eoc", {31'b0, busy}, 32'd1);
            check("no_valid_no_eoc", valid_cnt, v0);
            return;
        end
        eoc = 1'b0;
        repeat (408) @(negedge clk);
        check("sample_hold_end", sample, exp_sample);
        check("busy_during_eoc", {31'b0, busy}, 32'd1);
        push_expected(bits);
        eoc = 1'b1;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("busy_fall", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #(400_000 * 20);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int low;

        repeat (3) @(negedge clk);
        check("rst_cs", {31'b0, cs}, 32'd1);
        check("rst_adc_clk", {31'b0, ADC_clk}, 32'd0);
        check("rst_dout", {31'b0, data_out_adc}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sample", sample, 32'd0);
        check("rst_valid", {31'b0, sample_valid}, 32'd0);

        // Start on the same negedge reset releases: accepted at the first edge.
        rst = 1'b1;
        start_frame(4'hA);
        serve_frame(4'hA, 10'h02D, 0, 0, 1);
        repeat (5) @(negedge clk);
        check("valid_count_f1", valid_cnt, exp_valid);

        start_frame(4'hA);
        serve_frame(4'hA, 10'h0AD, 0, 0, 1);
        repeat (5) @(negedge clk);
        check("valid_count_f2", valid_cnt, exp_valid);

        start_frame(4'h3);
        serve_frame(4'h3, 10'h155, 1, 0, 1);

        start_frame(4'h6);
        serve_frame(4'h6, 10'h2D3, 0, 1, 1);
        repeat (20) @(negedge clk);
        check("poke_no_extra_frame", {31'b0, busy}, 32'd0);
        check("valid_count_poke", valid_cnt, exp_valid);

        start_frame(4'h9);
        serve_frame(4'h9, 10'h0AD, 0, 0, 0);
        apply_reset();
        rst = 1'b1;

        v0 = valid_cnt;
        start_frame(4'hA); serve_frame(4'hA, 10'h02D, 0, 0, 1);
        start_frame(4'hA); serve_frame(4'hA, 10'h0AD, 0, 0, 1);
        start_frame(4'hA); serve_frame(4'hA, 10'h02D, 0, 0, 1);
        start_frame(4'hA); serve_frame(4'hA, 10'h0AD, 0, 0, 1);
        repeat (5) @(negedge clk);
`ifdef ADC_AVG_EN
        check("four_frame_valids", valid_cnt - v0, 32'd1);
        check("four_frame_sample", sample, 32'h06D);
`else
        check("four_frame_valids", valid_cnt - v0, 32'd4);
        check("four_frame_sample", sample, 32'h0AD);
`endif

        // start held high: frames run back to back with one idle cycle.
        start = 1'b1;
        chan  = 4'h5;
        @(negedge clk);
        check("held_accept", {31'b0, busy}, 32'd1);
        serve_frame(4'h5, 10'h2D3, 0, 0, 1);
        low = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) break;
            low++;
        end
        check("idle_gap_cycles", low, 32'd1);
        start = 1'b0;
        serve_frame(4'h5, 10'h1C4, 0, 0, 1);
        repeat (20) @(negedge clk);
        check("held_final_idle", {31'b0, busy}, 32'd0);
        check("valid_count_end", valid_cnt, exp_valid);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
